sockit_spi_rpk: RTL and testbench



---
 rtl/sockit_spi_rpk_if.sv | 31 +++
 rtl/sockit_spi_rpk.sv | 147 ++++++++++++++
 tb/tb_sockit_spi_rpk.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/sockit_spi_rpk_if.sv
// Command-side and queue-side handshake bundle for the SPI output repackager.
// master drives commands and accepts segments; slave is the repackager itself.
interface sockit_spi_rpk_if #(
    parameter int SDW = 8,
    parameter int CDW = 32,
    parameter int LNW = 4,
    parameter int SDL = $clog2(SDW),
    parameter int CDL = $clog2(CDW),
    parameter int CCO = CDL + 8,
    parameter int QCO = SDL + 7,
    parameter int QDW = LNW * SDW
);
    logic           cmd_vld;
    logic [CCO-1:0] cmd_ctl;
    logic [CDW-1:0] cmd_dat;
    logic           cmd_rdy;
    logic           que_vld;
    logic [QCO-1:0] que_ctl;
    logic [QDW-1:0] que_dat;
    logic           que_rdy;

    modport master (
        output cmd_vld, cmd_ctl, cmd_dat, que_rdy,
        input  cmd_rdy, que_vld, que_ctl, que_dat
    );

    modport slave (
        input  cmd_vld, cmd_ctl, cmd_dat, que_rdy,
        output cmd_rdy, que_vld, que_ctl, que_dat
    );
endinterface

// File: rtl/sockit_spi_rpk.sv
// Output repackager: splits CDW-bit commands into serializer segments of up to
// SDW cycles spread across 1/2/4 lanes, with a registered one-per-clock queue output.
module sockit_spi_rpk #(
    parameter int   SDW = 8,
    parameter int   SDL = $clog2(SDW),
    parameter int   CDW = 32,
    parameter int   CDL = $clog2(CDW),
    parameter int   LNW = 4,
    parameter logic IDL = 1'b1,
    parameter int   CCO = CDL + 8,
    parameter int   QCO = SDL + 7,
    parameter int   QDW = LNW * SDW
) (
    input  logic             clk,
    input  logic             rst_n,
    sockit_spi_rpk_if.slave  bus
);
    localparam int CNW = CDL + 1;
    localparam int SLW = SDL + 1;

    typedef enum logic {IDLE, RUN} state_t;

    state_t         state_q, state_d;
    logic [CNW-1:0] cnt_q, cnt_d;
    logic [CDW-1:0] dat_q, dat_d;
    logic           pkm_q, pkm_d;
    logic [1:0]     lnm_q, lnm_d;
    logic [5:0]     low_q, low_d;
    logic           que_vld_q, que_vld_d;
    logic [QCO-1:0] que_ctl_q, que_ctl_d;
    logic [QDW-1:0] que_dat_q, que_dat_d;

    logic [SLW-1:0] seg_len;
    logic [SDL-1:0] rem;
    logic           seg_lst, ld, cmd_rdy, acc;
    logic [QDW-1:0] seg_dat;
    logic [CDW-1:0] dat_in, fill;
    logic [1:0]     iom_in, iom_out, lnm_in;
    int unsigned    lanes, sh, j;

    // Remainder goes first for pkm=1; afterwards the count is a multiple of SDW.
    always_comb begin
        rem = cnt_q[SDL-1:0];
        if (pkm_q) begin
            seg_len = (rem != '0) ? {1'b0, rem} : SLW'(SDW);
        end else begin
            seg_len = (|cnt_q[CNW-1:SDL]) ? SLW'(SDW) : {1'b0, rem};
        end
        seg_lst = (cnt_q == CNW'(seg_len));
        ld      = (state_q == RUN) && (!que_vld_q || bus.que_rdy);
        cmd_rdy = (state_q == IDLE) || (ld && seg_lst);
        acc     = bus.cmd_vld && cmd_rdy;
    end

    // dat_q always holds the stream MSB-first: stream bit j lives at dat_q[CDW-1-j].
    always_comb begin
        lanes   = 32'd1 << lnm_q;
        j       = 0;
        seg_dat = {QDW{IDL}};
        for (int unsigned l = 0; l < LNW; l++) begin
            for (int unsigned i = 0; i < SDW; i++) begin
                if (l < lanes && i < 32'(seg_len)) begin
                    j = (i << lnm_q) + lanes - 1 - l;
                    seg_dat[l*SDW + SDW-1-i] = (j < CDW) ? dat_q[CDW-1-j] : IDL;
                end
            end
        end
    end

    always_comb begin
        iom_in = bus.cmd_ctl[5:4];
        if (iom_in == 2'd3 && LNW >= 4) begin
            lnm_in  = 2'd2;
            iom_out = iom_in;
        end else if (iom_in == 2'd2 && LNW >= 2) begin
            lnm_in  = 2'd1;
            iom_out = iom_in;
        end else begin
            lnm_in  = 2'd0;
            iom_out = (iom_in[1]) ? 2'd1 : iom_in;
        end
        for (int unsigned i = 0; i < CDW; i++) begin
            dat_in[i] = bus.cmd_ctl[7] ? bus.cmd_dat[CDW-1-i] : bus.cmd_dat[i];
        end
        sh   = 32'(seg_len) << lnm_q;
        fill = ~({CDW{1'b1}} << sh);
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        dat_d     = dat_q;
        pkm_d     = pkm_q;
        lnm_d     = lnm_q;
        low_d     = low_q;
        que_vld_d = que_vld_q;
        que_ctl_d = que_ctl_q;
        que_dat_d = que_dat_q;
        if (ld) begin
            que_vld_d = 1'b1;
            que_ctl_d = {SDL'(seg_len - SLW'(1)), seg_lst, low_q};
            que_dat_d = seg_dat;
            cnt_d     = cnt_q - CNW'(seg_len);
            dat_d     = (dat_q << sh) | ({CDW{IDL}} & fill);
            if (seg_lst) state_d = IDLE;
        end else if (que_vld_q && bus.que_rdy) begin
            que_vld_d = 1'b0;
        end
        if (acc) begin
            state_d = RUN;
            cnt_d   = {1'b0, bus.cmd_ctl[CCO-1:8]} + CNW'(1);
            dat_d   = dat_in;
            pkm_d   = bus.cmd_ctl[6];
            lnm_d   = lnm_in;
            low_d   = {iom_out, bus.cmd_ctl[3:0]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            dat_q     <= '0;
            pkm_q     <= 1'b0;
            lnm_q     <= '0;
            low_q     <= '0;
            que_vld_q <= 1'b0;
            que_ctl_q <= '0;
            que_dat_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            dat_q     <= dat_d;
            pkm_q     <= pkm_d;
            lnm_q     <= lnm_d;
            low_q     <= low_d;
            que_vld_q <= que_vld_d;
            que_ctl_q <= que_ctl_d;
            que_dat_q <= que_dat_d;
        end
    end

    assign bus.cmd_rdy = cmd_rdy;
    assign bus.que_vld = que_vld_q;
    assign bus.que_ctl = que_ctl_q;
    assign bus.que_dat = que_dat_q;
endmodule

// File: tb/tb_sockit_spi_rpk.sv
// Directed bench for sockit_spi_rpk: table of commands with expected segments,
// plus hand sequences for latency, mid-transfer reset and LNW=1 lane clamping.
module tb_sockit_spi_rpk;
    localparam int SDW = 8;
    localparam int CDW = 32;
    localparam int LNW = 4;
    localparam int CCO = 13;
    localparam int QCO = 10;
    localparam int QDW = 32;
    localparam int NV  = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sockit_spi_rpk_if #(.SDW(SDW), .CDW(CDW), .LNW(LNW)) bus ();
    sockit_spi_rpk_if #(.SDW(SDW), .CDW(CDW), .LNW(1))   bus1 ();

    sockit_spi_rpk #(.SDW(SDW), .CDW(CDW), .LNW(LNW)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus.slave)
    );
    sockit_spi_rpk #(.SDW(SDW), .CDW(CDW), .LNW(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(bus1.slave)
    );

    typedef struct packed {
        logic [CCO-1:0]           ctl;
        logic [CDW-1:0]           dat;
        logic [2:0]               nseg;
        logic [3:0][QCO-1:0]      ectl;
        logic [3:0][QDW-1:0]      edat;
    } vec_t;

    vec_t tbl [NV];
    logic [QCO+QDW-1:0] expq [$];
    int nvec = 0;
    int nmis = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [CCO-1:0] mkctl(input int len, input bit lsb, input bit pkm,
                                             input int iom, input logic [3:0] lo);
        return {5'(len), lsb, pkm, 2'(iom), lo};
    endfunction

    function automatic logic [QCO-1:0] mkq(input int len, input bit lst, input logic [5:0] lo);
        return {3'(len), lst, lo};
    endfunction

    task automatic setv(input int i, input logic [CCO-1:0] c, input logic [CDW-1:0] d);
        tbl[i] = '0;
        tbl[i].ctl = c;
        tbl[i].dat = d;
    endtask

    task automatic adds(input int i, input logic [QCO-1:0] qc, input logic [QDW-1:0] qd);
        tbl[i].ectl[tbl[i].nseg] = qc;
        tbl[i].edat[tbl[i].nseg] = qd;
        tbl[i].nseg = tbl[i].nseg + 3'd1;
    endtask

    // pat 0: que_rdy held high, no bubbles allowed; pat 1: que_rdy pattern 1,0,0,1.
    task automatic run_table(input int pat);
        int ci = 0;
        int cyc = 0;
        bit stall = 0;
        bit seen = 0;
        logic [QCO-1:0] pc = '0;
        logic [QDW-1:0] pd = '0;
        logic [QCO+QDW-1:0] e;
        expq.delete();
        while ((ci < NV || expq.size() != 0) && cyc < 500) begin
            @(negedge clk);
            bus.que_rdy = (pat == 0) || (cyc % 4 == 0) || (cyc % 4 == 3);
            bus.cmd_vld = (ci < NV);
            if (ci < NV) begin
                bus.cmd_ctl = tbl[ci].ctl;
                bus.cmd_dat = tbl[ci].dat;
            end
            #1;
            if (stall) begin
                chk("stall_vld", bus.que_vld, 1);
                chk("stall_ctl", bus.que_ctl, pc);
                chk("stall_dat", bus.que_dat, pd);
            end
            if (bus.que_vld && !bus.que_rdy && expq.size() > 1)
                chk("stall_cmd_rdy", bus.cmd_rdy, 0);
            if (pat == 0 && seen && expq.size() != 0)
                chk("bubble", bus.que_vld, 1);
            if (bus.que_vld) seen = 1;
            if (bus.que_vld && bus.que_rdy) begin
                if (expq.size() == 0) begin
                    chk("extra_seg", 1, 0);
                end else begin
                    e = expq.pop_front();
                    chk("seg_ctl", bus.que_ctl, e[QCO+QDW-1:QDW]);
                    chk("seg_dat", bus.que_dat, e[QDW-1:0]);
                end
            end
            stall = bus.que_vld && !bus.que_rdy;
            pc = bus.que_ctl;
            pd = bus.que_dat;
            if (bus.cmd_vld && bus.cmd_rdy) begin
                for (int s = 0; s < int'(tbl[ci].nseg); s++)
                    expq.push_back({tbl[ci].ectl[s], tbl[ci].edat[s]});
                ci++;
            end
            cyc++;
        end
        chk("table_done", (ci == NV) && (expq.size() == 0), 1);
        @(negedge clk);
        bus.cmd_vld = 1'b0;
        bus.que_rdy = 1'b1;
    endtask

    task automatic run1(input string nm, input logic [CCO-1:0] c, input logic [CDW-1:0] d,
                        input logic [QCO-1:0] ec, input logic [7:0] ed);
        bit got = 0;
        @(negedge clk);
        bus1.cmd_ctl = c;
        bus1.cmd_dat = d;
        bus1.cmd_vld = 1'b1;
        for (int k = 0; k < 10 && !got; k++) begin
            @(negedge clk);
            bus1.cmd_vld = 1'b0;
            #1;
            if (bus1.que_vld) begin
                got = 1;
                chk({nm, "_ctl"}, bus1.que_ctl, ec);
                chk({nm, "_dat"}, bus1.que_dat, ed);
            end
        end
        chk({nm, "_seen"}, got, 1);
    endtask

    initial begin
        int nseg;
        bus.cmd_vld = 1'b0;  bus.cmd_ctl = '0;  bus.cmd_dat = '0;  bus.que_rdy = 1'b1;
        bus1.cmd_vld = 1'b0; bus1.cmd_ctl = '0; bus1.cmd_dat = '0; bus1.que_rdy = 1'b1;

        setv(0, mkctl(31, 0, 0, 1, 4'h5), 32'hA5C3_0F81);
        adds(0, mkq(7, 0, 6'h15), 32'hFFFF_FFA5);
        adds(0, mkq(7, 0, 6'h15), 32'hFFFF_FFC3);
        adds(0, mkq(7, 0, 6'h15), 32'hFFFF_FF0F);
        adds(0, mkq(7, 1, 6'h15), 32'hFFFF_FF81);
        setv(1, mkctl(10, 0, 1, 3, 4'h0), 32'h1234_5678);
        adds(1, mkq(2, 0, 6'h30), 32'h1F1F_7FBF);
        adds(1, mkq(7, 1, 6'h30), 32'h0FF7_3757);
        setv(2, mkctl(3, 1, 0, 2, 4'hA), 32'h0000_0006);
        adds(2, mkq(3, 1, 6'h2A), 32'hFFFF_4F8F);
        setv(3, mkctl(0, 0, 0, 0, 4'h3), 32'h0000_0000);
        adds(3, mkq(0, 1, 6'h03), 32'hFFFF_FF7F);
        setv(4, mkctl(10, 0, 0, 0, 4'h0), 32'hF000_0000);
        adds(4, mkq(7, 0, 6'h00), 32'hFFFF_FFF0);
        adds(4, mkq(2, 1, 6'h00), 32'hFFFF_FF1F);
        setv(5, mkctl(15, 0, 1, 1, 4'h0), 32'h3CA5_0000);
        adds(5, mkq(7, 0, 6'h10), 32'hFFFF_FF3C);
        adds(5, mkq(7, 1, 6'h10), 32'hFFFF_FFA5);
        setv(6, mkctl(7, 0, 0, 3, 4'h0), 32'h8421_8421);
        adds(6, mkq(7, 1, 6'h30), 32'h8844_2211);
        setv(7, mkctl(4, 0, 0, 2, 4'h0), 32'hC000_0000);
        adds(7, mkq(4, 1, 6'h20), 32'hFFFF_8787);

        repeat (2) @(negedge clk);
        #1;
        chk("rst_que_vld", bus.que_vld, 0);
        chk("rst_que_ctl", bus.que_ctl, 0);
        chk("rst_que_dat", bus.que_dat, 0);
        chk("rst_cmd_rdy", bus.cmd_rdy, 1);
        chk("rst1_cmd_rdy", bus1.cmd_rdy, 1);
        chk("rst1_que_vld", bus1.que_vld, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Accept at edge T, first segment visible after edge T+1.
        @(negedge clk);
        bus.cmd_ctl = mkctl(7, 0, 0, 1, 4'h0);
        bus.cmd_dat = 32'h5A00_0000;
        bus.cmd_vld = 1'b1;
        #1 chk("lat_cmd_rdy", bus.cmd_rdy, 1);
        @(negedge clk);
        bus.cmd_vld = 1'b0;
        #1 chk("lat_vld_t1", bus.que_vld, 0);
        @(negedge clk);
        #1;
        chk("lat_vld_t2", bus.que_vld, 1);
        chk("lat_ctl", bus.que_ctl, mkq(7, 1, 6'h10));
        chk("lat_dat", bus.que_dat, 32'hFFFF_FF5A);
        @(negedge clk);
        #1 chk("lat_drain", bus.que_vld, 0);

        run_table(0);
        run_table(1);

        // Reset while segment 2 of 4 sits in the queue register.
        @(negedge clk);
        bus.cmd_ctl = tbl[0].ctl;
        bus.cmd_dat = tbl[0].dat;
        bus.cmd_vld = 1'b1;
        bus.que_rdy = 1'b1;
        @(negedge clk);
        bus.cmd_vld = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1 chk("mid_seg2_dat", bus.que_dat, 32'hFFFF_FFC3);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_vld", bus.que_vld, 0);
        chk("mid_rst_rdy", bus.cmd_rdy, 1);
        @(negedge clk);
        rst_n = 1'b1;
        bus.cmd_ctl = mkctl(7, 0, 0, 1, 4'h0);
        bus.cmd_dat = 32'h9600_0000;
        bus.cmd_vld = 1'b1;
        nseg = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            bus.cmd_vld = 1'b0;
            #1;
            if (bus.que_vld && bus.que_rdy) begin
                nseg++;
                chk("post_rst_dat", bus.que_dat, 32'hFFFF_FF96);
            end
        end
        chk("post_rst_nseg", nseg, 1);

        run1("clamp_iom3", mkctl(7, 0, 0, 3, 4'h0), 32'h3C00_0000, mkq(7, 1, 6'h10), 8'h3C);
        run1("clamp_iom2", mkctl(7, 1, 0, 2, 4'h0), 32'h0000_0003, mkq(7, 1, 6'h10), 8'hC0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end
endmodule
